// File: rtl/seq_divider.sv
// Sequential signed divider: radix-2 restoring division on operand magnitudes,
// one quotient bit per clock, then sign correction. Z = {remainder, quotient}.
module seq_divider #(
   parameter int WIDTH = 32
) (
   input  logic               clk,
   input  logic               clear,
   input  logic               start,
   input  logic [WIDTH-1:0]   X,
   input  logic [WIDTH-1:0]   Y,
   output logic [2*WIDTH-1:0] Z,
   output logic               busy,
   output logic               done,
   output logic               dz
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t           state_r;
   state_t           state_nx_s;
   logic [WIDTH-1:0] a_r;
   logic [WIDTH-1:0] q_r;
   logic [WIDTH-1:0] ymag_r;
   logic [WIDTH-1:0] x_r;
   logic             sx_r;
   logic             sy_r;
   logic             zflag_r;
   logic [CW-1:0]    count_r;

   logic [WIDTH:0]   a_sh_s;
   logic [WIDTH:0]   t_s;
   logic [WIDTH-1:0] q_sh_s;

   function automatic logic [WIDTH-1:0] neg_f(input logic [WIDTH-1:0] v);
      return ~v + {{(WIDTH-1){1'b0}}, 1'b1};
   endfunction

   // Unsigned magnitude, so the most negative value maps to 2^(WIDTH-1) exactly
   function automatic logic [WIDTH-1:0] mag_f(input logic [WIDTH-1:0] v);
      return v[WIDTH-1] ? neg_f(v) : v;
   endfunction

   // One restoring step: the stored remainder is below |Y| so it fits in WIDTH
   // bits; only the shifted value needs the extra bit for the trial subtract.
   always_comb begin
      a_sh_s = {a_r, q_r[WIDTH-1]};
      q_sh_s = {q_r[WIDTH-2:0], 1'b0};
      t_s    = a_sh_s - {1'b0, ymag_r};
   end

   // Next-state logic
   always_comb begin
      state_nx_s = state_r;
      case (state_r)
         IDLE: begin
            if (start) state_nx_s = RUN;
            else       state_nx_s = IDLE;
         end
         RUN: begin
            if (count_r == CNT_LAST) state_nx_s = FIX;
            else                     state_nx_s = RUN;
         end
         FIX:     state_nx_s = DONE;
         DONE:    state_nx_s = IDLE;
         default: state_nx_s = IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clk or posedge clear) begin
      if (clear) state_r <= IDLE;
      else       state_r <= state_nx_s;
   end

   // Datapath and registered outputs
   always_ff @(posedge clk or posedge clear) begin
      if (clear) begin
         a_r     <= {WIDTH{1'b0}};
         q_r     <= {WIDTH{1'b0}};
         ymag_r  <= {WIDTH{1'b0}};
         x_r     <= {WIDTH{1'b0}};
         sx_r    <= 1'b0;
         sy_r    <= 1'b0;
         zflag_r <= 1'b0;
         count_r <= {CW{1'b0}};
         Z       <= {(2*WIDTH){1'b0}};
         busy    <= 1'b0;
         done    <= 1'b0;
         dz      <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (start) begin
                  a_r     <= {WIDTH{1'b0}};
                  q_r     <= mag_f(X);
                  ymag_r  <= mag_f(Y);
                  x_r     <= X;
                  sx_r    <= X[WIDTH-1];
                  sy_r    <= Y[WIDTH-1];
                  zflag_r <= (Y == {WIDTH{1'b0}});
                  count_r <= {CW{1'b0}};
                  busy    <= 1'b1;
               end
            end
            RUN: begin
               if (t_s[WIDTH]) begin
                  a_r <= a_sh_s[WIDTH-1:0];
                  q_r <= q_sh_s;
               end else begin
                  a_r <= t_s[WIDTH-1:0];
                  q_r <= {q_sh_s[WIDTH-1:1], 1'b1};
               end
               count_r <= count_r + CNT_ONE;
            end
            FIX: begin
               if (zflag_r) begin
                  Z  <= {x_r, {WIDTH{1'b1}}};
                  dz <= 1'b1;
               end else begin
                  Z[2*WIDTH-1:WIDTH] <= sx_r ? neg_f(a_r) : a_r;
                  Z[WIDTH-1:0]       <= (sx_r ^ sy_r) ? neg_f(q_r) : q_r;
                  dz <= 1'b0;
               end
               busy <= 1'b0;
               done <= 1'b1;
            end
            DONE: begin
               done <= 1'b0;
            end
            default: begin
               busy <= 1'b0;
               done <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: stimulus pushes expected results, a
// monitor pops and compares whenever done pulses.
module tb_seq_divider;

   logic        clk = 1'b0;
   logic        clear = 1'b1;
   logic        start = 1'b0;
   logic [31:0] X = 32'd0;
   logic [31:0] Y = 32'd0;
   logic [63:0] Z;
   logic        busy, done, dz;

   seq_divider #(.WIDTH(32)) dut (
      .clk(clk), .clear(clear), .start(start), .X(X), .Y(Y),
      .Z(Z), .busy(busy), .done(done), .dz(dz)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [63:0] z;
      logic        dzv;
      int          cyc;
      logic        rnd;
      logic [31:0] x;
      logic [31:0] y;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   n_chk = 0;
   int   n_fail = 0;
   int   cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Signed invariant X = Q*Y + R, |R| < |Y|, R zero or with the sign of X
   function automatic logic invariant_ok(input logic [31:0] x, input logic [31:0] y,
                                         input logic [63:0] z);
      longint q, r, xs, ys, ar, ay;
      q  = longint'($signed(z[31:0]));
      r  = longint'($signed(z[63:32]));
      xs = longint'($signed(x));
      ys = longint'($signed(y));
      ar = (r < 0) ? -r : r;
      ay = (ys < 0) ? -ys : ys;
      return (q * ys + r == xs) && (ar < ay) && ((r == 0) || ((r < 0) == (xs < 0)));
   endfunction

   // Monitor: every done pulse must match the oldest outstanding expectation
   always @(negedge clk) begin
      if (done === 1'b1) begin
         if (sb.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_done: Z=%h dz=%b, expected no result", Z, dz);
         end else begin
            mon_e = sb.pop_front();
            check("Z", Z, mon_e.z);
            check("dz", {63'd0, dz}, {63'd0, mon_e.dzv});
            check("latency", 64'(cyc), 64'(mon_e.cyc));
            if (mon_e.rnd) check("invariant", {63'd0, invariant_ok(mon_e.x, mon_e.y, Z)}, 64'd1);
         end
      end
   end

   task automatic issue(input logic [31:0] x, input logic [31:0] y, input logic [31:0] q,
                        input logic [31:0] r, input logic dzv, input logic rnd);
      @(negedge clk);
      X = x;
      Y = y;
      start = 1'b1;
      sb.push_back('{z: {r, q}, dzv: dzv, cyc: cyc + 34, rnd: rnd, x: x, y: y});
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   // Watch busy through the run, then the done pulse and its single-cycle width.
   // poke >= 0 scrambles the operands and pulses start mid-run.
   task automatic wait_done(input int poke);
      logic busy_ok = 1'b1;
      int   n = 0;
      if (poke >= 0) begin
         X = 32'd1;
         Y = 32'd1;
      end
      for (int i = 0; i < 33; i++) begin
         @(negedge clk);
         if (busy !== 1'b1) busy_ok = 1'b0;
         if (i == poke) start = 1'b1;
         if (i == poke + 1) start = 1'b0;
      end
      check("busy_held", {63'd0, busy_ok}, 64'd1);
      while (done !== 1'b1 && n < 10) begin
         @(negedge clk);
         n++;
      end
      check("done_seen", {63'd0, done}, 64'd1);
      check("busy_low_at_done", {63'd0, busy}, 64'd0);
      @(negedge clk);
      check("done_one_cycle", {63'd0, done}, 64'd0);
   endtask

   task automatic div(input logic [31:0] x, input logic [31:0] y, input logic [31:0] q,
                      input logic [31:0] r, input logic dzv);
      issue(x, y, q, r, dzv, 1'b0);
      wait_done(-5);
   endtask

   initial begin
      #100_000_000;
      $display("FAIL watchdog: simulation still running, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int xi, yi;
      repeat (3) @(negedge clk);
      check("reset_Z", Z, 64'd0);
      check("reset_busy", {61'd0, busy, done, dz}, 64'd0);
      clear = 1'b0;

      div(32'd7, 32'd2, 32'd3, 32'd1, 1'b0);
      div(-32'sd7, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
      div(32'd7, -32'sd2, 32'hFFFF_FFFD, 32'd1, 1'b0);
      div(-32'sd7, -32'sd2, 32'd3, 32'hFFFF_FFFF, 1'b0);
      div(32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0);
      div(32'h8000_0000, 32'd1, 32'h8000_0000, 32'd0, 1'b0);
      div(32'd3, 32'd10, 32'd0, 32'd3, 1'b0);
      div(32'd0, 32'd5, 32'd0, 32'd0, 1'b0);
      div(32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1'b1);
      div(32'd9, 32'd3, 32'd3, 32'd0, 1'b0);

      // Second start mid-run and operand changes must not disturb 100/7
      issue(32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b0);
      wait_done(8);

      // Clear mid-operation abandons the result
      issue(32'd50, 32'd5, 32'd10, 32'd0, 1'b0, 1'b0);
      repeat (14) @(negedge clk);
      clear = 1'b1;
      sb.delete();
      @(negedge clk);
      check("clear_Z", Z, 64'd0);
      check("clear_flags", {61'd0, busy, done, dz}, 64'd0);
      clear = 1'b0;
      repeat (40) @(negedge clk);
      check("clear_idle_busy", {63'd0, busy}, 64'd0);

      // Clear coincident with start wins
      X = 32'd50;
      Y = 32'd5;
      clear = 1'b1;
      start = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      start = 1'b0;
      repeat (2) @(negedge clk);
      check("clear_beats_start", {63'd0, busy}, 64'd0);

      div(32'd50, 32'd5, 32'd10, 32'd0, 1'b0);

      for (int k = 0; k < 1000; k++) begin
         xi = int'($urandom);
         if ($urandom_range(0, 1) == 0) yi = int'($urandom);
         else                           yi = int'($urandom_range(0, 200)) - 100;
         if (yi == 0) yi = 3;
         if (xi == int'(32'h8000_0000) && yi == -1) yi = 2;
         issue(32'(xi), 32'(yi), 32'(xi / yi), 32'(xi % yi), 1'b0, 1'b1);
         wait_done(-5);
      end

      repeat (3) @(negedge clk);
      if (sb.size() != 0) begin
         n_chk++;
         n_fail++;
         $display("FAIL pending_results: %0d outstanding, expected 0", sb.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
